// File: rtl/pulse_generator_if.sv
// pulse_generator_if: start/width request and pulse/busy/done status of a one-shot pulse generator
//   startPulse  request strobe, sampled only while the generator is idle
//   pulseWidth  requested width in time units
//   pulseOut    generated pulse
//   busy        high from acceptance through end of hold-off
//   done        one-cycle strobe on sequence completion
interface pulse_generator_if #(
  parameter int SIZE_PULSE_WIDTH = 10
) ();
  logic                        startPulse;
  logic [SIZE_PULSE_WIDTH-1:0] pulseWidth;
  logic                        pulseOut;
  logic                        busy;
  logic                        done;
  modport master (output startPulse, pulseWidth, input pulseOut, busy, done);
  modport slave (input startPulse, pulseWidth, output pulseOut, busy, done);
endinterface

// File: rtl/pulse_generator.sv
// pulse_generator: programmable one-shot pulse in ms/us/debug units followed by a forced hold-off gap
//   clk                  system clock, rising edge
//   resetPulseGenerator  asynchronous active-high reset
//   bus (slave)          startPulse/pulseWidth in, pulseOut/busy/done out (all outputs registered)
module pulse_generator #(
  parameter int FREQ_IN           = 12000000,
  parameter int SELECT_UNITS      = 1,
  parameter int LIMIT_PULSE_WIDTH = 1000,
  parameter int SIZE_PULSE_WIDTH  = $clog2(LIMIT_PULSE_WIDTH),
  parameter int HOLDOFF_UNITS     = 60
) (
  input logic               clk,
  input logic               resetPulseGenerator,
  pulse_generator_if.slave  bus
);
  localparam int UNIT_HZ = SELECT_UNITS > 1 ? SELECT_UNITS : (SELECT_UNITS != 0 ? 1000000 : 1000);
  localparam int CYCLES  = FREQ_IN / UNIT_HZ;
  localparam int PW      = CYCLES > 1 ? $clog2(CYCLES) : 1;
  localparam int UW      = SIZE_PULSE_WIDTH + 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYCLES - 1);
  localparam logic [UW-1:0] LIMIT_W   = UW'(LIMIT_PULSE_WIDTH);
  localparam logic [UW-1:0] HOLD_CNT  = UW'(HOLDOFF_UNITS);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  state_t        state, stateNext;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [UW-1:0] unitCount, unitCountNext, width, widthNext, unitLast;
  logic          pulseReg, pulseNext, busyReg, busyNext, doneReg, doneNext, unitTick;
  assign bus.pulseOut = pulseReg;
  assign bus.busy     = busyReg;
  assign bus.done     = doneReg;
  assign unitTick     = prescaler == PRE_LAST;
  assign unitLast     = unitCount + 1'b1;
  always_ff @(posedge clk or posedge resetPulseGenerator) begin
    if (resetPulseGenerator) begin
      state     <= IDLE;
      prescaler <= '0;
      unitCount <= '0;
      width     <= '0;
      pulseReg  <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      unitCount <= unitCountNext;
      width     <= widthNext;
      pulseReg  <= pulseNext;
      busyReg   <= busyNext;
      doneReg   <= doneNext;
    end
  end
  always_comb begin
    stateNext = state;
    widthNext = width;
    pulseNext = pulseReg;
    busyNext  = busyReg;
    doneNext  = 1'b0;
    case (state)
      IDLE:
        if (bus.startPulse && bus.pulseWidth != '0) begin
          widthNext = {1'b0, bus.pulseWidth} > LIMIT_W ? LIMIT_W : {1'b0, bus.pulseWidth};
          pulseNext = 1'b1;
          busyNext  = 1'b1;
          stateNext = PULSE;
        end
      PULSE:
        if (unitTick && unitLast == width) begin
          pulseNext = 1'b0;
          if (HOLDOFF_UNITS > 0) stateNext = HOLDOFF;
          else begin
            busyNext  = 1'b0;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end
        end
      HOLDOFF:
        if (unitTick && unitLast == HOLD_CNT) begin
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      default: stateNext = IDLE;
    endcase
    // Both counters restart from zero on every state change so each phase measures whole units.
    prescalerNext = (state == IDLE || stateNext != state || unitTick) ? '0 : prescaler + 1'b1;
    unitCountNext = (state == IDLE || stateNext != state) ? '0 : unitCount + UW'(unitTick);
  end
endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: scoreboard bench for pulse_generator with C=4 cycles/unit, limit 10, hold-off 2
module tb_pulse_generator;
  typedef struct {int pulseLen; int busyLen; int period;} exp_t;
  logic clk = 1'b0;
  logic clkEn = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulseRun = 0, busyRun = 0, lastPulse = 0, lastBusy = 0, lastDone = 0, activity = 0;
  logic busyFell = 1'b0;
  exp_t sb[$];
  exp_t e;
  pulse_generator_if #(.SIZE_PULSE_WIDTH(4)) bus ();
  pulse_generator #(
    .FREQ_IN(12000000),
    .SELECT_UNITS(3000000),
    .LIMIT_PULSE_WIDTH(10),
    .SIZE_PULSE_WIDTH(4),
    .HOLDOFF_UNITS(2)
  ) dut (
    .clk(clk),
    .resetPulseGenerator(rst),
    .bus(bus)
  );
  always #5 if (clkEn) clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      pulseRun  = 0;
      busyRun   = 0;
      lastPulse = 0;
      lastBusy  = 0;
      busyFell  = 1'b0;
    end else begin
      busyFell = 1'b0;
      if (bus.pulseOut) pulseRun++;
      else if (pulseRun != 0) begin
        lastPulse = pulseRun;
        pulseRun  = 0;
      end
      if (bus.busy) busyRun++;
      else if (busyRun != 0) begin
        lastBusy = busyRun;
        busyRun  = 0;
        busyFell = 1'b1;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_len", lastPulse, e.pulseLen);
          check("busy_len", busyFell ? lastBusy : 0, e.busyLen);
          if (e.period != 0) check("done_period", cyc - lastDone, e.period);
          lastPulse = 0;
        end
        lastDone = cyc;
      end
    end
  end
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    repeat (20) @(posedge clk);
  endtask
  task automatic quiet(input string name, input int cycles);
    activity = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.pulseOut || bus.busy || bus.done) activity++;
    end
    check(name, activity, 0);
  endtask
  initial begin
    bus.startPulse = 1'b0;
    bus.pulseWidth = '0;
    #3;
    check("reset_pulse", int'(bus.pulseOut), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    #2;
    rst   = 1'b0;
    clkEn = 1'b1;
    quiet("idle_quiet", 50);
    @(posedge clk) #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd5;
    sb.push_back('{20, 28, 0});
    @(posedge clk) #1;
    check("latency_pulse", int'(bus.pulseOut), 1);
    check("latency_busy", int'(bus.busy), 1);
    bus.startPulse = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd9;
    @(posedge clk) #1;
    bus.startPulse = 1'b0;
    drain("drain_single");
    @(posedge clk) #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd15;
    sb.push_back('{40, 48, 0});
    sb.push_back('{40, 48, 49});
    sb.push_back('{40, 48, 49});
    repeat (100) @(posedge clk);
    #1;
    bus.startPulse = 1'b0;
    drain("drain_clamped");
    @(posedge clk) #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.startPulse = 1'b0;
    quiet("zero_width_quiet", 20);
    @(posedge clk) #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd3;
    @(posedge clk) #1;
    bus.startPulse = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_pulse", int'(bus.pulseOut), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_done", int'(bus.done), 0);
    @(posedge clk) #2;
    rst = 1'b0;
    @(posedge clk) #1;
    bus.startPulse = 1'b1;
    bus.pulseWidth = 4'd1;
    sb.push_back('{4, 12, 0});
    @(posedge clk) #1;
    bus.startPulse = 1'b0;
    drain("drain_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
